wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_if.sv | 31 +++
 rtl/wb_port_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: writeback-stage request, multi-cycle result
// input, register-file write port and status outputs.
// "slave" is the arbiter's view; "master" is the surrounding pipeline's view.
interface wb_port_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          RegWriteW;
  logic [4:0]    RdW;
  logic [31:0]   ResultW;
  logic          mc_valid;
  logic [4:0]    mc_rd;
  logic [31:0]   mc_data;
  logic          mc_ready;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_wd;
  logic          stall_req;
  logic [CW-1:0] buf_count;

  modport master (
    output RegWriteW, RdW, ResultW, mc_valid, mc_rd, mc_data,
    input  mc_ready, rf_we, rf_rd, rf_wd, stall_req, buf_count
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, mc_valid, mc_rd, mc_data,
    output mc_ready, rf_we, rf_rd, rf_wd, stall_req, buf_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the writeback stage and a
// multi-cycle unit. Multi-cycle results are queued in a small FIFO and written
// on cycles the pipeline does not use the port.
// Optional macro WB_ARB_STARVE_GUARD_EN: builds a starve counter that forces a
// one-cycle pipeline stall so a long-waiting buffered result gets the port.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // FIFO storage; small enough that a same-cycle head read is cheap.
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q;

  logic pipe_req;
  logic pipe_grant;
  logic head_grant;
  logic ready;
  logic push;

  // A pipe write to x0 is a no-op and must never take the port from the buffer.
  assign pipe_req   = bus.RegWriteW && (bus.RdW != 5'd0);
  assign pipe_grant = !rst && !stall_q && pipe_req;
  assign head_grant = !rst && !pipe_grant && (count_q != '0);

  // Readiness looks only at the registered count, so a same-cycle pop does
  // not open a slot early.
  assign ready = !rst && (count_q < CW'(DEPTH));
  // Results for x0 are accepted but dropped.
  assign push  = bus.mc_valid && ready && (bus.mc_rd != 5'd0);

  // Next-state for pointers and occupancy; pointers wrap at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(head_grant);
    if (push)       wr_ptr_d = wr_ptr_q + PW'(1);
    if (head_grant) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Occupancy and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Store accepted results at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= bus.mc_rd;
      data_mem_q[wr_ptr_q] <= bus.mc_data;
    end
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          stall_d;

  // Count consecutive waiting cycles of a non-empty buffer; request a stall
  // once it has waited STARVE_MAX cycles. The stall cycle always pops, so the
  // request lasts exactly one cycle.
  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    if ((count_q != '0) && !head_grant) begin
      starve_d = starve_q + SW'(1);
      stall_d  = (starve_q == SW'(STARVE_MAX - 1));
    end
  end

  // Starve counter and registered stall request.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  // Write-port mux: pipe first unless stalled, then buffer head, else idle zeros.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_rd = 5'd0;
    bus.rf_wd = 32'd0;
    if (pipe_grant) begin
      bus.rf_we = 1'b1;
      bus.rf_rd = bus.RdW;
      bus.rf_wd = bus.ResultW;
    end else if (head_grant) begin
      bus.rf_we = 1'b1;
      bus.rf_rd = rd_mem_q[rd_ptr_q];
      bus.rf_wd = data_mem_q[rd_ptr_q];
    end
  end

  assign bus.mc_ready  = ready;
  assign bus.stall_req = !rst && stall_q;
  assign bus.buf_count = rst ? '0 : count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_wb_port_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: queue of pending results, waiting-cycle tally.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  int   waited  = 0;
  bit   stall_m = 1'b0;

  // Last sampled outputs, for hand-written checks.
  logic        o_ready, o_we, o_stall;
  logic [4:0]  o_rd;
  logic [31:0] o_wd;
  int          o_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit r, input bit we, input logic [4:0] rd, input logic [31:0] res,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    bit          e_ready, e_stall, e_we, popped, was_busy;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    int          e_cnt;
    @(negedge clk);
    rst           = r;
    bus.RegWriteW = we;
    bus.RdW       = rd;
    bus.ResultW   = res;
    bus.mc_valid  = mv;
    bus.mc_rd     = mrd;
    bus.mc_data   = md;
    #2;
    e_ready = !r && (q.size() < DEPTH);
    e_stall = !r && stall_m;
    e_cnt   = r ? 0 : q.size();
    e_we = 1'b0; e_rd = 5'd0; e_wd = 32'd0; popped = 1'b0;
    if (!r) begin
      if (!e_stall && we && rd != 5'd0) begin
        e_we = 1'b1; e_rd = rd; e_wd = res;
      end else if (q.size() > 0) begin
        e_we = 1'b1; e_rd = q[0].rd; e_wd = q[0].d; popped = 1'b1;
      end
    end
    o_ready = bus.mc_ready;
    o_we    = bus.rf_we;
    o_rd    = bus.rf_rd;
    o_wd    = bus.rf_wd;
    o_stall = bus.stall_req;
    o_cnt   = int'(bus.buf_count);
    check("model_mc_ready",  32'(o_ready), 32'(e_ready));
    check("model_rf_we",     32'(o_we),    32'(e_we));
    check("model_rf_rd",     32'(o_rd),    32'(e_rd));
    check("model_rf_wd",     o_wd,         e_wd);
    check("model_stall_req", 32'(o_stall), 32'(e_stall));
    check("model_buf_count", 32'(o_cnt),   32'(e_cnt));
    @(posedge clk);
    if (r) begin
      q.delete();
      waited  = 0;
      stall_m = 1'b0;
    end else begin
      was_busy = (q.size() > 0);
      if (popped) void'(q.pop_front());
      if (mv && e_ready && mrd != 5'd0) q.push_back('{rd: mrd, d: md});
`ifdef WB_ARB_STARVE_GUARD_EN
      // A buffered result that has waited STARVE_MAX cycles forces a stall.
      if (popped || !was_busy) begin
        waited  = 0;
        stall_m = 1'b0;
      end else begin
        waited  = waited + 1;
        stall_m = (waited == STARVE_MAX);
      end
`else
      stall_m = 1'b0;
`endif
    end
  endtask

  typedef struct {
    bit          r;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] res;
    bit          mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    bit          x_ready;
    bit          x_we;
    logic [4:0]  x_rd;
    logic [31:0] x_wd;
    bit          x_stall;
    int          x_cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    rst           = 1'b1;
    bus.RegWriteW = 1'b0;
    bus.RdW       = 5'd0;
    bus.ResultW   = 32'd0;
    bus.mc_valid  = 1'b0;
    bus.mc_rd     = 5'd0;
    bus.mc_data   = 32'd0;

    //           r  we rd  res           mv mrd md            | rdy we rd wd            st cnt
    tbl[0]  = '{1, 0, 0, 32'h0,        1, 9, 32'h99,        0,  0, 0, 32'h0,        0, 0};
    tbl[1]  = '{0, 0, 0, 32'h0,        1, 5, 32'hDEADBEEF,  1,  0, 0, 32'h0,        0, 0};
    tbl[2]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         1,  1, 5, 32'hDEADBEEF, 0, 1};
    tbl[3]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 32'h0,        0, 0};
    tbl[4]  = '{0, 1, 2, 32'h22,       1, 8, 32'h88,        1,  1, 2, 32'h22,       0, 0};
    tbl[5]  = '{0, 1, 3, 32'h11,       0, 0, 32'h0,         1,  1, 3, 32'h11,       0, 1};
    tbl[6]  = '{0, 1, 0, 32'hFFFF,     0, 0, 32'h0,         1,  1, 8, 32'h88,       0, 1};
    tbl[7]  = '{0, 0, 0, 32'h0,        1, 7, 32'h77,        1,  0, 0, 32'h0,        0, 0};
    tbl[8]  = '{0, 1, 0, 32'h1234,     1, 0, 32'h55,        1,  1, 7, 32'h77,       0, 1};
    tbl[9]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 32'h0,        0, 0};
    tbl[10] = '{0, 0, 0, 32'h0,        1, 0, 32'h66,        1,  0, 0, 32'h0,        0, 0};
    tbl[11] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,         1,  0, 0, 32'h0,        0, 0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].we, tbl[i].rd, tbl[i].res, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      check($sformatf("vec%0d_ready", i), 32'(o_ready), 32'(tbl[i].x_ready));
      check($sformatf("vec%0d_we", i),    32'(o_we),    32'(tbl[i].x_we));
      check($sformatf("vec%0d_rd", i),    32'(o_rd),    32'(tbl[i].x_rd));
      check($sformatf("vec%0d_wd", i),    o_wd,         tbl[i].x_wd);
      check($sformatf("vec%0d_stall", i), 32'(o_stall), 32'(tbl[i].x_stall));
      check($sformatf("vec%0d_cnt", i),   32'(o_cnt),   32'(tbl[i].x_cnt));
    end

    // Fill to DEPTH under continuous pipe traffic; third result refused.
    step(0, 1, 1, 32'hA0, 1, 10, 32'h10A);
    check("full_a_ready", 32'(o_ready), 32'd1);
    step(0, 1, 1, 32'hA1, 1, 11, 32'h10B);
    check("full_b_cnt", 32'(o_cnt), 32'd1);
    step(0, 1, 1, 32'hA2, 1, 12, 32'h10C);
    check("full_c_ready", 32'(o_ready), 32'd0);
    check("full_c_cnt",   32'(o_cnt),   32'd2);
    step(0, 0, 0, 32'h0,  1, 13, 32'h10D);
    check("full_d_ready", 32'(o_ready), 32'd0);
    check("full_d_rd",    32'(o_rd),    32'd10);
    step(0, 0, 0, 32'h0,  0, 0, 32'h0);
    check("full_e_rd",    32'(o_rd),    32'd11);
    step(0, 0, 0, 32'h0,  0, 0, 32'h0);
    check("full_f_we",    32'(o_we),    32'd0);
    check("full_f_cnt",   32'(o_cnt),   32'd0);

    // Starvation: one buffered entry behind continuous pipe requests.
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h100, 1, 20, 32'hA5);
    for (int k = 1; k <= 4; k++) step(0, 1, 1, 32'h100 + 32'(k), 0, 0, 32'h0);
    check("starve_p4_stall", 32'(o_stall), 32'd0);
    step(0, 1, 1, 32'h105, 0, 0, 32'h0);
`ifdef WB_ARB_STARVE_GUARD_EN
    check("starve_p5_stall", 32'(o_stall), 32'd1);
    check("starve_p5_rd",    32'(o_rd),    32'd20);
    check("starve_p5_wd",    o_wd,         32'hA5);
`else
    check("starve_p5_stall", 32'(o_stall), 32'd0);
    check("starve_p5_rd",    32'(o_rd),    32'd1);
`endif
    step(0, 1, 1, 32'h105, 0, 0, 32'h0);
    check("starve_p6_stall", 32'(o_stall), 32'd0);
    check("starve_p6_rd",    32'(o_rd),    32'd1);
    check("starve_p6_wd",    o_wd,         32'h105);
`ifdef WB_ARB_STARVE_GUARD_EN
    check("starve_p6_cnt",   32'(o_cnt),   32'd0);
`else
    check("starve_p6_cnt",   32'(o_cnt),   32'd1);
`endif

    // Reset with a full buffer drops entries without writing them.
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, 1, 32'hB0, 1, 21, 32'h21);
    step(0, 1, 1, 32'hB1, 1, 22, 32'h22);
    step(1, 0, 0, 32'h0, 1, 23, 32'h23);
    check("rst_a_we",    32'(o_we),    32'd0);
    check("rst_a_cnt",   32'(o_cnt),   32'd0);
    check("rst_a_ready", 32'(o_ready), 32'd0);
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    check("rst_b_we",    32'(o_we),    32'd0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check("rst_rel_ready", 32'(o_ready), 32'd1);
    check("rst_rel_cnt",   32'(o_cnt),   32'd0);
    check("rst_rel_we",    32'(o_we),    32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bit          r, we, mv;
      logic [4:0]  rd, mrd;
      r   = ($urandom_range(0, 63) == 0);
      we  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mv  = ($urandom_range(0, 2) == 0);
      mrd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(r, we, rd, $urandom, mv, mrd, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
